// File: rtl/rgb_code_encoder.sv
// rgb_code_encoder: debounced push buttons edit a 3-bit RGB code (clear > load > inc > dec).
// Define RGB_ENC_REPEAT_EN to enable auto-repeat of the increment button while held.
module rgb_code_encoder #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_CYCLES   = 62500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic [1:0] sw,
   output logic [2:0] code,
   output logic       code_valid
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be at least 1");
   end
   logic [3:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [1:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [3:0]    db_q, db_d, prev_q, prev_d;
   logic [DW-1:0] cnt_q [4];
   logic [DW-1:0] cnt_d [4];
   logic [3:0]    ev;
   logic [2:0]    code_q, code_d;
   logic          valid_q, valid_d;
   always_comb begin
      btn_s1_d = btn;
      btn_s2_d = btn_s1_q;
      sw_s1_d  = sw;
      sw_s2_d  = sw_s1_q;
      prev_d   = db_q;
      db_d     = db_q;
      // the level flips on the edge the count would reach DEBOUNCE_CYCLES
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (btn_s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) db_d[i] = btn_s2_q[i];
            else cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end
`ifdef RGB_ENC_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES + 1);
   logic [RW-1:0] rpt_q, rpt_d;
   logic          rep;
   // counter holds cycles since the press (or last repeat) while btn[0] stays down
   always_comb begin
      rep   = db_q[0] && (rpt_q == RW'(REPEAT_CYCLES));
      rpt_d = !db_q[0] ? '0 : rep ? RW'(1) : rpt_q + 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rpt_q <= '0;
      else rpt_q <= rpt_d;
   end
   assign ev = (db_q & ~prev_q) | {3'b000, rep};
`else
   assign ev = db_q & ~prev_q;
`endif
   always_comb begin
      code_d  = ev[3] ? 3'b000 :
                ev[2] ? {sw_s2_q, code_q[0]} :
                ev[0] ? code_q + 3'd1 :
                ev[1] ? code_q - 3'd1 : code_q;
      valid_d = |ev;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
         db_q     <= '0;
         prev_q   <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      end else begin
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         sw_s1_q  <= sw_s1_d;
         sw_s2_q  <= sw_s2_d;
         db_q     <= db_d;
         prev_q   <= prev_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end
   assign code       = code_q;
   assign code_valid = valid_q;
endmodule
